// File: rtl/pll_seq_pkg.sv
// Shared state encoding and sizing constants for the PLL enable sequencer.
package pll_seq_pkg;

    localparam int STATE_W = 3;
    localparam int OUT_N   = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_PWRUP_WAIT  = 3'd1,
        ST_LOCK_WAIT   = 3'd2,
        ST_LOCK_STABLE = 3'd3,
        ST_ENABLE_OUTS = 3'd4,
        ST_RUN         = 3'd5,
        ST_RETRY_OFF   = 3'd6,
        ST_FAULT       = 3'd7
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_enable_sequencer.sv
// Power-up / lock sequencer for one PLL: settle, enable, qualify lock, stagger
// the output clock enables, and power-cycle with bounded retries on failure.
module pll_enable_sequencer
    import pll_seq_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int PWRUP_DELAY     = 16,
    parameter int LOCK_TIMEOUT    = 1000,
    parameter int LOCK_STABLE_CYC = 32,
    parameter int STAGGER         = 4,
    parameter int MAX_RETRIES     = 3
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic               LOCK,
    input  logic [OUT_N-1:0]   OUT_EN_REQ,
    output logic               PLL_EN,
    output logic [OUT_N-1:0]   CLK_OUT_EN,
    output logic               READY,
    output logic               FAULT,
    output logic [STATE_W-1:0] STATE,
    output logic [3:0]         RETRY_CNT
);

    // Stagger counter needs headroom for STAGGER*OUT_N-1.
    localparam int STAG_W = CNT_W + 2;

    localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(PWRUP_DELAY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam bit               RETRY_LIMITED = (MAX_RETRIES <= 15);
    localparam logic [3:0]       RETRY_MAX_V   = RETRY_LIMITED ? 4'(MAX_RETRIES) : 4'd15;

    state_t              state_reg;
    logic [CNT_W-1:0]    dly_cnt_reg;
    logic [CNT_W-1:0]    tmo_cnt_reg;
    logic [CNT_W-1:0]    stab_cnt_reg;
    logic [STAG_W-1:0]   stag_cnt_reg;
    logic [OUT_N-1:0]    grant_reg;
    logic [3:0]          retry_cnt_reg;
    logic                pll_en_reg;
    logic [OUT_N-1:0]    clk_out_en_reg;
    logic                ready_reg;
    logic                fault_reg;

    logic                lock_s;
    logic [OUT_N-1:0]    grant_hit;
    logic [OUT_N-1:0]    grant_next;
    logic                retries_exhausted;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (LOCK),
        .q     (lock_s)
    );

    for (genvar gi = 0; gi < OUT_N; gi++) begin : g_grant
        assign grant_hit[gi] = (stag_cnt_reg == STAG_W'(STAGGER * (gi + 1) - 1));
    end

    assign grant_next        = grant_reg | grant_hit;
    assign retries_exhausted = RETRY_LIMITED && (retry_cnt_reg == RETRY_MAX_V);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= ST_IDLE;
            dly_cnt_reg    <= '0;
            tmo_cnt_reg    <= '0;
            stab_cnt_reg   <= '0;
            stag_cnt_reg   <= '0;
            grant_reg      <= '0;
            retry_cnt_reg  <= '0;
            pll_en_reg     <= 1'b0;
            clk_out_en_reg <= '0;
            ready_reg      <= 1'b0;
            fault_reg      <= 1'b0;
        end else if (!START && state_reg != ST_IDLE) begin
            // Shutdown outranks every other event; also the only exit from FAULT.
            state_reg      <= ST_IDLE;
            dly_cnt_reg    <= '0;
            tmo_cnt_reg    <= '0;
            stab_cnt_reg   <= '0;
            stag_cnt_reg   <= '0;
            grant_reg      <= '0;
            retry_cnt_reg  <= '0;
            pll_en_reg     <= 1'b0;
            clk_out_en_reg <= '0;
            ready_reg      <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (START) begin
                        state_reg     <= ST_PWRUP_WAIT;
                        retry_cnt_reg <= '0;
                        dly_cnt_reg   <= '0;
                    end
                end
                ST_PWRUP_WAIT: begin
                    if (dly_cnt_reg == PWRUP_LAST) begin
                        state_reg    <= ST_LOCK_WAIT;
                        pll_en_reg   <= 1'b1;
                        tmo_cnt_reg  <= '0;
                        stab_cnt_reg <= '0;
                    end else begin
                        dly_cnt_reg <= dly_cnt_reg + 1'b1;
                    end
                end
                ST_LOCK_WAIT: begin
                    if (tmo_cnt_reg == TMO_LAST) begin
                        state_reg      <= ST_RETRY_OFF;
                        pll_en_reg     <= 1'b0;
                        clk_out_en_reg <= '0;
                        ready_reg      <= 1'b0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        if (lock_s) begin
                            state_reg    <= ST_LOCK_STABLE;
                            stab_cnt_reg <= CNT_W'(1);
                        end
                    end
                end
                ST_LOCK_STABLE: begin
                    // Timeout keeps running here so a bouncing lock still fails.
                    if (tmo_cnt_reg == TMO_LAST) begin
                        state_reg      <= ST_RETRY_OFF;
                        pll_en_reg     <= 1'b0;
                        clk_out_en_reg <= '0;
                        ready_reg      <= 1'b0;
                    end else if (!lock_s) begin
                        state_reg    <= ST_LOCK_WAIT;
                        stab_cnt_reg <= '0;
                        tmo_cnt_reg  <= tmo_cnt_reg + 1'b1;
                    end else if (stab_cnt_reg == STABLE_LAST) begin
                        state_reg    <= ST_ENABLE_OUTS;
                        stag_cnt_reg <= '0;
                        grant_reg    <= '0;
                    end else begin
                        stab_cnt_reg <= stab_cnt_reg + 1'b1;
                        tmo_cnt_reg  <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_ENABLE_OUTS: begin
                    if (!lock_s) begin
                        state_reg      <= ST_RETRY_OFF;
                        pll_en_reg     <= 1'b0;
                        clk_out_en_reg <= '0;
                        ready_reg      <= 1'b0;
                    end else if (grant_reg[OUT_N-1]) begin
                        state_reg      <= ST_RUN;
                        ready_reg      <= 1'b1;
                        clk_out_en_reg <= OUT_EN_REQ;
                    end else begin
                        stag_cnt_reg   <= stag_cnt_reg + 1'b1;
                        grant_reg      <= grant_next;
                        clk_out_en_reg <= grant_next & OUT_EN_REQ;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_reg      <= ST_RETRY_OFF;
                        pll_en_reg     <= 1'b0;
                        clk_out_en_reg <= '0;
                        ready_reg      <= 1'b0;
                    end else begin
                        clk_out_en_reg <= OUT_EN_REQ;
                    end
                end
                ST_RETRY_OFF: begin
                    if (retries_exhausted) begin
                        state_reg <= ST_FAULT;
                        fault_reg <= 1'b1;
                    end else begin
                        state_reg   <= ST_PWRUP_WAIT;
                        dly_cnt_reg <= '0;
                        if (retry_cnt_reg != 4'd15) begin
                            retry_cnt_reg <= retry_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    state_reg <= ST_FAULT;
                end
            endcase
        end
    end

    assign PLL_EN     = pll_en_reg;
    assign CLK_OUT_EN = clk_out_en_reg;
    assign READY      = ready_reg;
    assign FAULT      = fault_reg;
    assign STATE      = state_reg;
    assign RETRY_CNT  = retry_cnt_reg;

endmodule

// File: tb/tb_pll_enable_sequencer.sv
// Directed bench for pll_enable_sequencer; cycle numbers count clock edges after START is driven.
`timescale 1ns/1ps
module tb_pll_enable_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       LOCK = 1'b0;
    logic [3:0] OUT_EN_REQ = 4'h0;
    logic       PLL_EN;
    logic [3:0] CLK_OUT_EN;
    logic       READY;
    logic       FAULT;
    logic [2:0] STATE;
    logic [3:0] RETRY_CNT;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;
    logic saw_stable;
    logic saw_enable;

    pll_enable_sequencer #(
        .CNT_W           (16),
        .PWRUP_DELAY     (4),
        .LOCK_TIMEOUT    (100),
        .LOCK_STABLE_CYC (8),
        .STAGGER         (2),
        .MAX_RETRIES     (2)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .LOCK       (LOCK),
        .OUT_EN_REQ (OUT_EN_REQ),
        .PLL_EN     (PLL_EN),
        .CLK_OUT_EN (CLK_OUT_EN),
        .READY      (READY),
        .FAULT      (FAULT),
        .STATE      (STATE),
        .RETRY_CNT  (RETRY_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s @cyc %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int e);
        while (cyc < e) tick();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        START = 1'b0;
        LOCK  = 1'b0;
        tick();
        tick();
        check("rst_pll_en", 32'(PLL_EN), 0);
        check("rst_clk_out_en", 32'(CLK_OUT_EN), 0);
        check("rst_ready", 32'(READY), 0);
        check("rst_fault", 32'(FAULT), 0);
        check("rst_state", 32'(STATE), 0);
        check("rst_retry", 32'(RETRY_CNT), 0);
        RST_N = 1'b1;
        tick();
        cyc = 0;
    endtask

    initial begin
        // ---- Scenarios 1, 4 and 6: nominal bring-up, lock loss in RUN, async reset pulse
        do_reset();
        OUT_EN_REQ = 4'hF;
        START = 1'b1;
        run_to(4);  check("s1_pwrup_low", 32'(PLL_EN), 0);
                    check("s1_pwrup_state", 32'(STATE), 1);
        run_to(5);  check("s1_pll_en_rise", 32'(PLL_EN), 1);
                    check("s1_lock_wait", 32'(STATE), 2);
        run_to(25); LOCK = 1'b1;
        run_to(27); check("s1_still_wait", 32'(STATE), 2);
        run_to(28); check("s1_lock_stable", 32'(STATE), 3);
        run_to(34); check("s1_stable_hold", 32'(STATE), 3);
        run_to(35); check("s1_enable_outs", 32'(STATE), 4);
                    check("s1_en_none", 32'(CLK_OUT_EN), 0);
        run_to(36); check("s1_en_36", 32'(CLK_OUT_EN), 0);
        run_to(37); check("s1_en_bit0", 32'(CLK_OUT_EN), 4'h1);
        run_to(38); check("s1_en_38", 32'(CLK_OUT_EN), 4'h1);
        run_to(39); check("s1_en_bit1", 32'(CLK_OUT_EN), 4'h3);
        run_to(41); check("s1_en_bit2", 32'(CLK_OUT_EN), 4'h7);
        run_to(43); check("s1_en_bit3", 32'(CLK_OUT_EN), 4'hF);
                    check("s1_ready_early", 32'(READY), 0);
        run_to(44); check("s1_ready", 32'(READY), 1);
                    check("s1_run", 32'(STATE), 5);
                    check("s1_retry", 32'(RETRY_CNT), 0);
        run_to(46); check("s4_en_before_req", 32'(CLK_OUT_EN), 4'hF);
                    OUT_EN_REQ = 4'b0101;
        run_to(47); check("s4_en_follow_req", 32'(CLK_OUT_EN), 4'b0101);
        run_to(50); LOCK = 1'b0;
        run_to(52); check("s4_run_during_sync", 32'(STATE), 5);
                    check("s4_ready_during_sync", 32'(READY), 1);
        run_to(53); check("s4_retry_off", 32'(STATE), 6);
                    check("s4_off_en", 32'(CLK_OUT_EN), 0);
                    check("s4_off_ready", 32'(READY), 0);
                    check("s4_off_pll", 32'(PLL_EN), 0);
                    LOCK = 1'b1;
        run_to(54); check("s4_pwrup", 32'(STATE), 1);
                    check("s4_retry1", 32'(RETRY_CNT), 1);
        run_to(57); check("s4_pwrup_low", 32'(PLL_EN), 0);
        run_to(58); check("s4_pll_en", 32'(PLL_EN), 1);
        run_to(66); check("s4_enable_outs", 32'(STATE), 4);
        run_to(68); check("s4_en_bit0", 32'(CLK_OUT_EN), 4'b0001);
        run_to(72); check("s4_en_bit2", 32'(CLK_OUT_EN), 4'b0101);
        run_to(74); check("s4_ready_early", 32'(READY), 0);
        run_to(75); check("s4_ready", 32'(READY), 1);
                    check("s4_run", 32'(STATE), 5);
                    check("s4_run_en", 32'(CLK_OUT_EN), 4'b0101);
                    check("s4_run_retry", 32'(RETRY_CNT), 1);
        run_to(77); check("s6_pre_ready", 32'(READY), 1);
        #2; RST_N = 1'b0;
        #1; check("s6_async_pll", 32'(PLL_EN), 0);
            check("s6_async_en", 32'(CLK_OUT_EN), 0);
            check("s6_async_ready", 32'(READY), 0);
            check("s6_async_state", 32'(STATE), 0);
            check("s6_async_retry", 32'(RETRY_CNT), 0);
            check("s6_async_fault", 32'(FAULT), 0);
        START = 1'b0;
        #2; RST_N = 1'b1;
        run_to(80); check("s6_idle_hold", 32'(STATE), 0);
                    check("s6_idle_pll", 32'(PLL_EN), 0);
                    START = 1'b1;
        run_to(81); check("s6_restart", 32'(STATE), 1);
                    START = 1'b0;
        run_to(82); check("s6_stop", 32'(STATE), 0);

        // ---- Scenario 2: lock never arrives, retries run out
        do_reset();
        OUT_EN_REQ = 4'hF;
        START = 1'b1;
        run_to(5);   check("s2_p1_rise", 32'(PLL_EN), 1);
        run_to(104); check("s2_p1_last", 32'(PLL_EN), 1);
        run_to(105); check("s2_p1_fall", 32'(PLL_EN), 0);
                     check("s2_retry_off1", 32'(STATE), 6);
        run_to(106); check("s2_retry1", 32'(RETRY_CNT), 1);
                     check("s2_pwrup1", 32'(STATE), 1);
        run_to(109); check("s2_gap_low", 32'(PLL_EN), 0);
        run_to(110); check("s2_p2_rise", 32'(PLL_EN), 1);
        run_to(209); check("s2_p2_last", 32'(PLL_EN), 1);
        run_to(210); check("s2_p2_fall", 32'(PLL_EN), 0);
        run_to(211); check("s2_retry2", 32'(RETRY_CNT), 2);
        run_to(215); check("s2_p3_rise", 32'(PLL_EN), 1);
        run_to(314); check("s2_p3_last", 32'(PLL_EN), 1);
        run_to(315); check("s2_retry_off3", 32'(STATE), 6);
                     check("s2_no_fault_yet", 32'(FAULT), 0);
        run_to(316); check("s2_fault", 32'(FAULT), 1);
                     check("s2_fault_state", 32'(STATE), 7);
                     check("s2_fault_pll", 32'(PLL_EN), 0);
        run_to(320); check("s2_fault_sticky", 32'(STATE), 7);
                     START = 1'b0;
        run_to(321); check("s2_idle", 32'(STATE), 0);
                     check("s2_fault_clear", 32'(FAULT), 0);

        // ---- Scenario 3: bouncing lock (5 high, 1 low) must time out
        do_reset();
        OUT_EN_REQ = 4'hF;
        START = 1'b1;
        saw_stable = 1'b0;
        saw_enable = 1'b0;
        while (cyc < 104) begin
            tick();
            if (STATE == 3'd3) saw_stable = 1'b1;
            if (STATE == 3'd4) saw_enable = 1'b1;
            if (cyc >= 5) LOCK = (((cyc - 5) % 6) != 5);
        end
        check("s3_saw_stable", 32'(saw_stable), 1);
        check("s3_no_enable", 32'(saw_enable), 0);
        check("s3_pll_last", 32'(PLL_EN), 1);
        run_to(105); check("s3_timeout", 32'(STATE), 6);
                     check("s3_pll_fall", 32'(PLL_EN), 0);
        run_to(106); check("s3_retry1", 32'(RETRY_CNT), 1);
                     START = 1'b0;
        run_to(107); check("s3_idle", 32'(STATE), 0);

        // ---- Scenario 5: START dropped during ENABLE_OUTS after grant[1]
        do_reset();
        OUT_EN_REQ = 4'hF;
        START = 1'b1;
        LOCK = 1'b1;
        run_to(13); check("s5_enable_outs", 32'(STATE), 4);
        run_to(17); check("s5_en_bit1", 32'(CLK_OUT_EN), 4'h3);
                    START = 1'b0;
        run_to(18); check("s5_idle", 32'(STATE), 0);
                    check("s5_pll_off", 32'(PLL_EN), 0);
                    check("s5_en_off", 32'(CLK_OUT_EN), 0);
                    check("s5_no_fault", 32'(FAULT), 0);
                    check("s5_no_ready", 32'(READY), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
